// File: rtl/vote_collector16_if.sv
// vote_collector16_if: serial vote input, word output and status counters of the vote collector.
interface vote_collector16_if;
    logic        vote_valid;
    logic        vote_bit;
    logic        vote_ready;
    logic        flush;
    logic        word_valid;
    logic [15:0] word_data;
    logic        word_ready;
    logic [4:0]  vote_cnt;
    logic [7:0]  frame_cnt;
    modport master (
        output vote_valid, vote_bit, flush, word_ready,
        input  vote_ready, word_valid, word_data, vote_cnt, frame_cnt
    );
    modport slave (
        input  vote_valid, vote_bit, flush, word_ready,
        output vote_ready, word_valid, word_data, vote_cnt, frame_cnt
    );
endinterface

// File: rtl/vote_collector16.sv
// vote_collector16: packs 16 serial votes into a word for the majority stage.
// Flush always wins over a same-cycle vote or word handshake.
module vote_collector16 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    vote_collector16_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  frm_q, frm_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  idx;
    assign idx = MSB_FIRST ? 4'd15 - cnt_q[3:0] : cnt_q[3:0];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frm_d   = frm_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: state_d = COLLECT;
            COLLECT: begin
                if (bus.flush) begin
                    cnt_d = 5'd0;
                end else if (bus.vote_valid) begin
                    data_d[idx] = bus.vote_bit;
                    cnt_d       = cnt_q + 5'd1;
                    state_d     = (cnt_q == 5'd15) ? FULL : COLLECT;
                end
            end
            FULL: begin
                if (bus.flush || bus.word_ready) begin
                    state_d = COLLECT;
                    cnt_d   = 5'd0;
                    frm_d   = bus.flush ? frm_q : frm_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            frm_q   <= 8'd0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
            data_q  <= data_d;
        end
    end
    assign bus.vote_ready = (state_q == COLLECT);
    assign bus.word_valid = (state_q == FULL);
    assign bus.word_data  = data_q;
    assign bus.vote_cnt   = cnt_q;
    assign bus.frame_cnt  = frm_q;
endmodule

// File: tb/tb_vote_collector16.sv
// tb_vote_collector16: directed checks of the vote collector; a second instance runs MSB_FIRST=1 on the same stimulus.
module tb_vote_collector16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    vote_collector16_if b0();
    vote_collector16_if b1();
    vote_collector16 #(.MSB_FIRST(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    vote_collector16 #(.MSB_FIRST(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    assign b1.vote_valid = b0.vote_valid;
    assign b1.vote_bit   = b0.vote_bit;
    assign b1.flush      = b0.flush;
    assign b1.word_ready = b0.word_ready;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send16(input logic [15:0] pat);
        for (int i = 0; i < 16; i++) begin
            b0.vote_valid = 1'b1;
            b0.vote_bit   = pat[i];
            step();
        end
        b0.vote_valid = 1'b0;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_vready"}, {15'd0, b0.vote_ready}, 16'd0);
        chk({tag, "_wvalid"}, {15'd0, b0.word_valid}, 16'd0);
        chk({tag, "_vcnt"},   {11'd0, b0.vote_cnt}, 16'd0);
        chk({tag, "_fcnt"},   {8'd0, b0.frame_cnt}, 16'd0);
        chk({tag, "_data"},   b0.word_data, 16'h0000);
    endtask
    initial begin
        b0.vote_valid = 1'b0;
        b0.vote_bit   = 1'b0;
        b0.flush      = 1'b1;
        b0.word_ready = 1'b1;
        #2;
        chk_reset("rst");
        #10 rst_n = 1'b1;
        step();
        chk("idle_flush_ignored", {15'd0, b0.vote_ready}, 16'd1);
        b0.flush = 1'b0;
        // First frame: 1,0,1,0... with word_ready already high
        send16(16'h5555);
        chk("f1_wvalid", {15'd0, b0.word_valid}, 16'd1);
        chk("f1_data_lsb", b0.word_data, 16'h5555);
        chk("f1_data_msb", b1.word_data, 16'hAAAA);
        chk("f1_vcnt16", {11'd0, b0.vote_cnt}, 16'd16);
        chk("f1_vready0", {15'd0, b0.vote_ready}, 16'd0);
        step();
        chk("f1_wvalid_drop", {15'd0, b0.word_valid}, 16'd0);
        chk("f1_fcnt", {8'd0, b0.frame_cnt}, 16'd1);
        chk("f1_vcnt0", {11'd0, b0.vote_cnt}, 16'd0);
        // Backpressure: word held while votes keep arriving
        b0.word_ready = 1'b0;
        send16(16'hC3A5);
        b0.vote_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b0.vote_bit = i[0];
            step();
            chk("bp_vready", {15'd0, b0.vote_ready}, 16'd0);
            chk("bp_data", b0.word_data, 16'hC3A5);
            chk("bp_vcnt", {11'd0, b0.vote_cnt}, 16'd16);
        end
        b0.word_ready = 1'b1;
        step();
        b0.vote_valid = 1'b0;
        chk("bp_rel_vcnt", {11'd0, b0.vote_cnt}, 16'd0);
        chk("bp_rel_fcnt", {8'd0, b0.frame_cnt}, 16'd2);
        // Flush mid-frame together with a vote
        for (int i = 0; i < 7; i++) begin
            b0.vote_valid = 1'b1;
            b0.vote_bit   = 1'b1;
            step();
        end
        chk("fl_vcnt7", {11'd0, b0.vote_cnt}, 16'd7);
        b0.flush = 1'b1;
        step();
        b0.flush = 1'b0;
        b0.vote_valid = 1'b0;
        chk("fl_vcnt0", {11'd0, b0.vote_cnt}, 16'd0);
        chk("fl_fcnt", {8'd0, b0.frame_cnt}, 16'd2);
        chk("fl_vready", {15'd0, b0.vote_ready}, 16'd1);
        send16(16'hFFFF);
        chk("ones_data", b0.word_data, 16'hFFFF);
        step();
        chk("ones_fcnt", {8'd0, b0.frame_cnt}, 16'd3);
        // Flush beats the word handshake
        b0.word_ready = 1'b0;
        send16(16'h0000);
        chk("zero_data", b0.word_data, 16'h0000);
        b0.flush = 1'b1;
        b0.word_ready = 1'b1;
        step();
        b0.flush = 1'b0;
        chk("flhs_vready", {15'd0, b0.vote_ready}, 16'd1);
        chk("flhs_wvalid", {15'd0, b0.word_valid}, 16'd0);
        chk("flhs_fcnt", {8'd0, b0.frame_cnt}, 16'd3);
        chk("flhs_vcnt", {11'd0, b0.vote_cnt}, 16'd0);
        // Back-to-back frames: 17 cycles each, vote_valid never dropped
        b0.vote_valid = 1'b1;
        for (int i = 0; i < 252 * 17; i++) begin
            b0.vote_bit = 1'($urandom_range(0, 1));
            step();
        end
        chk("b2b_fcnt255", {8'd0, b0.frame_cnt}, 16'd255);
        for (int i = 0; i < 17; i++) begin
            b0.vote_bit = 1'($urandom_range(0, 1));
            step();
        end
        chk("b2b_wrap", {8'd0, b0.frame_cnt}, 16'd0);
        chk("b2b_vready", {15'd0, b0.vote_ready}, 16'd1);
        for (int i = 0; i < 5; i++) step();
        chk("mid_vcnt5", {11'd0, b0.vote_cnt}, 16'd5);
        // Asynchronous reset between edges
        b0.vote_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("arst");
        #1 rst_n = 1'b1;
        step();
        chk("arst_collect", {15'd0, b0.vote_ready}, 16'd1);
        chk("arst_vcnt", {11'd0, b0.vote_cnt}, 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vote_collector16.md
VOTE_COLLECTOR16 -- requirements
Module: vote_collector16

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0: 0 = first accepted vote lands in word_data[0]; 1 = first accepted vote lands in word_data[15].
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port vote_valid, input, 1, upstream asserts when vote_bit is valid.
REQ-005 SHALL have port vote_bit, input, 1, the single serial vote.
REQ-006 SHALL have port vote_ready, output, 1, block can accept a vote this cycle.
REQ-007 SHALL have port flush, input, 1, synchronous abort of the frame in progress or held.
REQ-008 SHALL have port word_valid, output, 1, word_data holds a complete 16-vote frame.
REQ-009 SHALL have port word_data, output, 16, assembled frame, driven to the majority stage's Data input.
REQ-010 SHALL have port word_ready, input, 1, downstream accepts the word this cycle.
REQ-011 SHALL have port vote_cnt, output, 5, votes accepted in the current frame (0..16).
REQ-012 SHALL have port frame_cnt, output, 8, frames delivered since reset; wraps 255->0.

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, FULL.
REQ-014 SHALL decode vote_ready = (state==COLLECT) and word_valid = (state==FULL), with no other logic.
REQ-015 SHALL, in IDLE, move to COLLECT on the next rising edge unconditionally.
REQ-016 SHALL accept a vote on each edge where vote_valid && vote_ready is high: write vote_bit into word_data[vote_cnt] (MSB_FIRST=0) or word_data[15-vote_cnt] (MSB_FIRST=1), and increment vote_cnt.
REQ-017 SHALL, on acceptance while vote_cnt==15, set vote_cnt=16 and move to FULL; word_valid is high the following cycle (1-cycle latency from the 16th vote).
REQ-018 SHALL ignore vote_valid when vote_ready is low; vote_bit is don't-care there.
REQ-019 SHALL, in FULL, hold word_data and vote_cnt stable until word_valid && word_ready is high.
REQ-020 SHALL, on that handshake, move to COLLECT, clear vote_cnt to 0, and increment frame_cnt modulo 256.
REQ-021 SHALL allow word_ready high before word_valid; it has no effect outside FULL.
REQ-022 SHALL, when flush is high in COLLECT or FULL, clear vote_cnt to 0 and go to COLLECT next edge; frame_cnt unchanged.
REQ-023 SHALL give flush priority over a same-cycle vote acceptance: the vote is discarded.
REQ-024 SHALL give flush priority over a same-cycle word handshake: no frame_cnt increment.
REQ-025 SHALL ignore flush in IDLE.
REQ-026 SHALL not require word_data bits beyond vote_cnt to be cleared during partial frames; they are only valid when word_valid is high.
REQ-027 SHALL allow back-to-back frames with no bubble other than the single FULL-to-COLLECT turnaround cycle.

Reset
REQ-028 SHALL, while rst_n is low, force state=IDLE, vote_cnt=0, frame_cnt=0, word_data=16'h0000, vote_ready=0, and word_valid=0, independent of clk.
REQ-029 SHALL, on rst_n assertion mid-frame or in FULL, discard the frame immediately; the first edge after release enters COLLECT.

Verification
REQ-030 SHALL cover the following directed scenario: reset release, then 16 votes pattern 1,0,1,0... with MSB_FIRST=0 and word_ready=1 -> word_valid for exactly 1 cycle, word_data=16'h5555, frame_cnt=1.
REQ-031 SHALL cover the following directed scenario: same 16 votes with MSB_FIRST=1 -> word_data=16'hAAAA.
REQ-032 SHALL cover the following directed scenario: frame complete, word_ready=0 for 5 cycles, vote_valid held high -> vote_ready=0, word_data stable, vote_cnt=16; then word_ready=1 -> vote_cnt=0, frame_cnt increments by 1.
REQ-033 SHALL cover the following directed scenario: 7 votes, then flush together with vote_valid=1 -> vote_cnt=0, the 8th vote discarded, frame_cnt unchanged; then 16 all-ones votes -> word_data=16'hFFFF.
REQ-034 SHALL cover the following directed scenario: flush in the same cycle as the word handshake -> state COLLECT, frame_cnt unchanged.
REQ-035 SHALL cover the following directed scenario: 256 back-to-back frames -> frame_cnt wraps to 0; rst_n pulsed low mid-frame between clock edges -> all outputs at reset values immediately.
